cpu_step_clock: RTL and testbench
=================================

Name: cpu_step_clock

Overview:
- Upstream clock-enable generator for the CPU on the board. It sits between the pushbutton/switch inputs and the CPU's clock-enable input.
- Step mode: a debounced pushbutton press releases exactly one CPU cycle.
- Run mode: the CPU advances at a fixed divided rate.
- Also drives a mode LED and an optional executed-step counter for the 7-segment display path.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a new button level (10 ms at 50 MHz); legal range >= 1.
- RUN_DIV, 5000000, clk cycles per cpu_en pulse in run mode (10 Hz at 50 MHz); legal range >= 2.

Ports:
- clk  in  1  board clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- step_btn  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk.
- run_sw  in  1  raw slide switch, asynchronous to clk; 1 = run mode, 0 = step mode.
- cpu_en  out  1  registered one-cycle clock-enable pulse to the CPU.
- run_mode  out  1  registered mode indicator for an LED; 1 = RUN state.
- step_count  out  16  count of cpu_en pulses issued (see Optional Feature).

Behaviour:
- Reset (reset=0, async): all outputs are 0. Both synchronizer chains reset to their idle levels: step_btn chain to 1, run_sw chain to 0. Debounced button level = 1, debounce counter = 0, divider = 0, FSM = STEP.
- Synchronizers: step_btn and run_sw each pass through a 2-flop synchronizer. Only the synchronized values (btn_s, sw_s) are used after that point.
- Debounce counter:
  - When btn_s equals the debounced level (btn_db), the counter clears to 0.
  - While they differ, the counter increments each cycle.
  - When the counter equals DEBOUNCE_CYCLES-1 and they still differ: btn_db <= btn_s and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_db.
- Press event: a btn_db 1->0 transition, detected the cycle after btn_db updates. A release (0->1) is not an event. Holding the button produces exactly one event.
- FSM states: STEP, RUN.
  - STEP -> RUN when sw_s=1. RUN -> STEP when sw_s=0. The transition is evaluated every cycle.
  - run_mode is 1 exactly in the cycles where the registered state is RUN.
- STEP state: cpu_en=1 for exactly one cycle, in the cycle after the press event is detected. Otherwise cpu_en=0.
- RUN state:
  - The divider counts 0..RUN_DIV-1 and wraps to 0.
  - cpu_en=1 in the cycle after the divider equals RUN_DIV-1. The period is exactly RUN_DIV cycles.
  - Press events are ignored.
- Entering RUN clears the divider to 0, so the first pulse occurs RUN_DIV cycles after run_mode rises.
- Leaving RUN: no cpu_en pulse is issued in the transition cycle, and the divider holds at 0.
- Simultaneous events: if a mode change and a press event (or divider terminal count) fall in the same cycle, the mode change wins and no cpu_en pulse is generated.
- Reset mid-operation: an in-flight debounce, divider count or pending pulse is discarded, and the block returns to STEP.
- cpu_en is never high on two consecutive cycles.

Optional Feature:
- Macro: CPU_STEP_CLOCK_COUNT_EN.
- Defined: step_count is a 16-bit register, reset to 0. It increments by 1 in the same cycle cpu_en is high, in both modes, and wraps 0xFFFF -> 0x0000.
- Undefined: step_count is tied to 16'h0000 and no counter logic is synthesized.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=5, macro defined):
- Reset: hold reset=0 with random inputs -> cpu_en=0, run_mode=0, step_count=0. Release reset -> outputs stay 0 while step_btn=1 and run_sw=0.
- Clean press: step_btn low for 20 cycles, then high -> exactly one cpu_en pulse, 8 cycles (2 synchronizer + 4 debounce + 2 register) after the first low sample, then step_count=1. No pulse on release.
- Bounce: step_btn pulses low for 3 cycles, high for 2, repeated 5 times -> no cpu_en pulse and step_count stays 0.
- Run mode: set run_sw=1 for 32 cycles -> run_mode rises 3 cycles after the switch changes. cpu_en then pulses every 5 cycles with the first pulse 5 cycles after run_mode rises, giving 5 pulses within the window. step_count increments once per pulse.
- Press in run / mode change: hold a press during run mode -> no extra pulses. Set run_sw=0 in the same cycle the divider hits terminal count -> no pulse, run_mode falls, divider holds at 0.
- Wrap and mid-run reset: preload the counter to 0xFFFF via forced stimulus and step once -> step_count=0x0000. Assert reset mid-run -> all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/cpu_step_clock.sv
// cpu_step_clock: clock-enable generator for the board CPU.
// Step mode releases one CPU cycle per debounced button press; run mode
// releases one CPU cycle every RUN_DIV clocks. Optional executed-step
// counter is built only when CPU_STEP_CLOCK_COUNT_EN is defined;
// otherwise step_count reads as zero.
module cpu_step_clock #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RUN_DIV         = 5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step_btn,
  input  logic        run_sw,
  output logic        cpu_en,
  output logic        run_mode,
  output logic [15:0] step_count
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

  // Bit 0 is the button (idles high, active-low), bit 1 the switch (idles low).
  localparam logic [1:0] SYNC_IDLE = 2'b01;

  typedef enum logic {ST_STEP, ST_RUN} state_t;

  logic [1:0] raw_in;
  logic [1:0] sync_bits;
  logic       btn_s;
  logic       sw_s;

  logic [DB_W-1:0]  db_cnt_reg;
  logic             btn_db_reg;
  logic             btn_db_d_reg;
  logic             press_reg;

  state_t           state_reg;
  state_t           state_next;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             cpu_en_reg;
  logic             cpu_en_next;

  assign raw_in = {run_sw, step_btn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      // Two-flop synchronizer; resets to the input's idle level so no
      // spurious press or mode change is seen as reset releases.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          meta_reg <= SYNC_IDLE[gi];
          sync_reg <= SYNC_IDLE[gi];
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_bits[gi] = sync_reg;
    end
  endgenerate

  assign btn_s = sync_bits[0];
  assign sw_s  = sync_bits[1];

  // Debounce: accept a new button level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt_reg <= '0;
      btn_db_reg <= 1'b1;
    end else if (btn_s == btn_db_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_MAX) begin
      db_cnt_reg <= '0;
      btn_db_reg <= btn_s;
    end else begin
      db_cnt_reg <= db_cnt_reg + DB_W'(1);
    end
  end

  // Press event: falling edge of the debounced level, registered one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_db_d_reg <= 1'b1;
      press_reg    <= 1'b0;
    end else begin
      btn_db_d_reg <= btn_db_reg;
      press_reg    <= btn_db_d_reg & ~btn_db_reg;
    end
  end

  // Mode FSM, run-rate divider and cpu_en state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_STEP;
      div_reg    <= '0;
      cpu_en_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      div_reg    <= div_next;
      cpu_en_reg <= cpu_en_next;
    end
  end

  // Next-state logic: a mode change takes priority and suppresses any pulse
  // in that cycle; the divider is cleared on every mode change.
  always_comb begin
    state_next  = state_reg;
    div_next    = div_reg;
    cpu_en_next = 1'b0;
    case (state_reg)
      ST_STEP: begin
        if (sw_s) begin
          state_next = ST_RUN;
          div_next   = '0;
        end else begin
          cpu_en_next = press_reg;
        end
      end
      ST_RUN: begin
        if (!sw_s) begin
          state_next = ST_STEP;
          div_next   = '0;
        end else if (div_reg == DIV_MAX) begin
          div_next    = '0;
          cpu_en_next = 1'b1;
        end else begin
          div_next = div_reg + DIV_W'(1);
        end
      end
      default: begin
        state_next = ST_STEP;
        div_next   = '0;
      end
    endcase
  end

  assign cpu_en   = cpu_en_reg;
  assign run_mode = (state_reg == ST_RUN);

`ifdef CPU_STEP_CLOCK_COUNT_EN
  logic [15:0] count_reg;

  // Executed-step counter; updates together with cpu_en so the display
  // already includes the pulse being issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= 16'h0000;
    end else if (cpu_en_next) begin
      count_reg <= count_reg + 16'h0001;
    end
  end

  assign step_count = count_reg;
`else
  assign step_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_step_clock.sv
// Self-checking bench for cpu_step_clock with DEBOUNCE_CYCLES=4, RUN_DIV=5.
// A behavioural model predicts cpu_en, run_mode and step_count every cycle.
module tb_cpu_step_clock;

  localparam int DEB = 4;
  localparam int DIV = 5;

  logic        clk;
  logic        reset;
  logic        step_btn;
  logic        run_sw;
  logic        cpu_en;
  logic        run_mode;
  logic [15:0] step_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state
  int hist_btn [3];
  int hist_sw  [3];
  int m_db;
  int m_diff_run;
  int m_fall_edge;
  int m_mode;
  int m_run_entry;
  int exp_en;
  int exp_cnt;
  int pulses_seen;

  cpu_step_clock #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_DIV        (DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .step_btn  (step_btn),
    .run_sw    (run_sw),
    .cpu_en    (cpu_en),
    .run_mode  (run_mode),
    .step_count(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist_btn[i] = 1;
      hist_sw[i]  = 0;
    end
    m_db        = 1;
    m_diff_run  = 0;
    m_fall_edge = -100;
    m_mode      = 0;
    m_run_entry = 0;
    exp_en      = 0;
    exp_cnt     = 0;
  endtask

  // Apply the block's rules for one rising edge numbered cyc.
  task automatic model_edge();
    int btn_s_pre;
    int mode_prev;
    hist_btn[2] = hist_btn[1];
    hist_btn[1] = hist_btn[0];
    hist_btn[0] = int'(step_btn);
    hist_sw[2]  = hist_sw[1];
    hist_sw[1]  = hist_sw[0];
    hist_sw[0]  = int'(run_sw);
    // Synchronized values seen by this edge were sampled two edges earlier.
    btn_s_pre = hist_btn[2];
    mode_prev = m_mode;
    m_mode    = hist_sw[2];
    if (btn_s_pre != m_db) begin
      m_diff_run++;
      if (m_diff_run == DEB) begin
        if (m_db == 1) m_fall_edge = cyc;
        m_db       = btn_s_pre;
        m_diff_run = 0;
      end
    end else begin
      m_diff_run = 0;
    end
    exp_en = 0;
    if (mode_prev == 0 && m_mode == 0 && m_fall_edge == cyc - 2) exp_en = 1;
    if (mode_prev == 1 && m_mode == 1 && ((cyc - m_run_entry) % DIV) == 0) exp_en = 1;
    if (mode_prev == 0 && m_mode == 1) m_run_entry = cyc;
    exp_cnt = (exp_cnt + exp_en) & 16'hFFFF;
  endtask

  // One clock: model updates at the rising edge, outputs checked at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!reset) model_reset();
    else model_edge();
    @(negedge clk);
    check_eq("cpu_en", int'(cpu_en), exp_en);
    check_eq("run_mode", int'(run_mode), m_mode);
`ifdef CPU_STEP_CLOCK_COUNT_EN
    check_eq("step_count", int'(step_count), exp_cnt);
`else
    check_eq("step_count", int'(step_count), 0);
`endif
    if (cpu_en) begin
      pulses_seen++;
      $display("cycle %0d: cpu_en pulse, run_mode=%0d, step_count=%0d", cyc, run_mode, step_count);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int lat;
    int rise;
    int first;
    int base;
    int guard;

    reset    = 1'b0;
    step_btn = 1'b1;
    run_sw   = 1'b0;
    pulses_seen = 0;
    model_reset();

    // Reset held with random inputs: all outputs stay 0.
    for (int i = 0; i < 6; i++) begin
      step_btn = 1'($urandom);
      run_sw   = 1'($urandom);
      tick();
    end
    step_btn = 1'b1;
    run_sw   = 1'b0;
    ticks(3);
    reset = 1'b1;
    ticks(6);

    // Clean press: one pulse 8 cycles after the first low sample.
    lat = -1;
    base = pulses_seen;
    step_btn = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_en && lat < 0) lat = i;
    end
    check_eq("press_latency", lat, 8);
    step_btn = 1'b1;
    ticks(20);
    check_eq("press_pulse_count", pulses_seen - base, 1);

    // Bounce: low pulses shorter than the debounce window never register.
    base = pulses_seen;
    for (int r = 0; r < 5; r++) begin
      step_btn = 1'b0;
      ticks(3);
      step_btn = 1'b1;
      ticks(2);
    end
    ticks(10);
    check_eq("bounce_pulses", pulses_seen - base, 0);

    // Run mode window of 32 cycles.
    rise = -1;
    first = -1;
    base = pulses_seen;
    run_sw = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (run_mode && rise < 0) rise = i;
      if (cpu_en && first < 0) first = i;
    end
    check_eq("run_rise", rise, 3);
    check_eq("run_first_pulse", first - rise, 5);
    check_eq("run_pulses_in_window", pulses_seen - base, 5);

    // Press held during run mode is ignored.
    step_btn = 1'b0;
    ticks(15);
    step_btn = 1'b1;
    ticks(10);

    // Drop the switch so the mode change lands on a divider terminal count.
    guard = 0;
    while (((cyc + 3 - m_run_entry) % DIV) != 0 && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("tc_align_bound", int'(guard < 20), 1);
    base = pulses_seen;
    run_sw = 1'b0;
    ticks(3);
    check_eq("tc_no_pulse", pulses_seen - base, 0);
    check_eq("tc_run_mode_low", int'(run_mode), 0);
    check_eq("tc_div_zero", int'(dut.div_reg), 0);
    ticks(6);
    check_eq("div_holds_zero", int'(dut.div_reg), 0);

    // Randomized mix of presses, bounces and mode toggles.
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          step_btn = 1'b0;
          ticks($urandom_range(1, 12));
          step_btn = 1'b1;
          ticks($urandom_range(1, 8));
        end
        1: begin
          run_sw = ~run_sw;
          ticks($urandom_range(1, 20));
        end
        2: ticks($urandom_range(1, 8));
        default: begin
          for (int k = 0; k < 6; k++) begin
            step_btn = 1'($urandom);
            tick();
          end
          step_btn = 1'b1;
        end
      endcase
    end
    run_sw   = 1'b0;
    step_btn = 1'b1;
    ticks(12);

`ifdef CPU_STEP_CLOCK_COUNT_EN
    // Counter wrap from 0xFFFF on the next step.
    force dut.count_reg = 16'hFFFF;
    #1;
    release dut.count_reg;
    exp_cnt = 16'hFFFF;
    ticks(2);
    check_eq("preload", int'(step_count), 16'hFFFF);
    step_btn = 1'b0;
    ticks(12);
    step_btn = 1'b1;
    ticks(6);
    check_eq("wrap_to_zero", int'(step_count), 0);
`endif

    // Reset asserted mid-run clears outputs without waiting for a clock.
    run_sw = 1'b1;
    ticks(12);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_rst_cpu_en", int'(cpu_en), 0);
    check_eq("async_rst_run_mode", int'(run_mode), 0);
    check_eq("async_rst_step_count", int'(step_count), 0);
    model_reset();
    ticks(3);
    run_sw = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ticks(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
